// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, bubble instruction and immediate-format helpers.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_REG      = 7'h33;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;
  function automatic imm_type_e imm_type(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: return IMM_I;
      OP_STORE:                            return IMM_S;
      OP_BRANCH:                           return IMM_B;
      OP_LUI, OP_AUIPC:                    return IMM_U;
      OP_JAL:                              return IMM_J;
      default:                             return IMM_NONE;
    endcase
  endfunction
  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, x0 hardwired to zero, write-through bypass on both read ports.
module regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic            w_we;
  assign w_we = i_we && (i_wa != 5'd0);
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k < NREGS; k++) r_regs[k] <= '0;
    end else if (w_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end
  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : (w_we && i_wa == i_ra1) ? i_wd : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : (w_we && i_wa == i_ra2) ? i_wd : r_regs[i_ra2];
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with IF/ID register, immediate generator, register file and illegal-opcode flag.
module id_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_present,
  input  logic [31:0]     inst,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            illegal
);
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  imm_type_e       w_imm_type;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= NOP_INST;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else if (!stall) begin
      r_valid <= 1'b1;
      r_pc    <= pc_present;
      r_inst  <= inst;
    end
  end
  assign id_valid = r_valid;
  assign id_pc    = r_pc;
  assign id_inst  = r_inst;
  assign opcode   = r_inst[6:0];
  assign rd       = r_inst[11:7];
  assign funct3   = r_inst[14:12];
  assign rs1      = r_inst[19:15];
  assign rs2      = r_inst[24:20];
  assign funct7   = r_inst[31:25];
  assign illegal  = r_valid && !legal_op(r_inst[6:0]);
  assign w_imm_type = imm_type(r_inst[6:0]);
  always_comb begin
    imm = '0;
    case (w_imm_type)
      IMM_I:   imm = {{20{r_inst[31]}}, r_inst[31:20]};
      IMM_S:   imm = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
      IMM_B:   imm = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
      IMM_U:   imm = {r_inst[31:12], 12'b0};
      IMM_J:   imm = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .i_we  (wb_en),
    .i_wa  (wb_rd),
    .i_wd  (wb_data),
    .i_ra1 (r_inst[19:15]),
    .i_ra2 (r_inst[24:20]),
    .o_rd1 (rs1_data),
    .o_rd2 (rs2_data)
  );
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scoreboard bench for the RV32I decode stage.
module tb_id_stage;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
  logic [31:0] pc_present = '0, inst = '0, wb_data = '0;
  logic [4:0]  wb_rd = '0;
  logic        id_valid, illegal;
  logic [31:0] id_pc, id_inst, imm, rs1_data, rs2_data;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] imm;
    logic        ill;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  id_stage dut (
    .clk(clk), .reset(reset), .pc_present(pc_present), .inst(inst), .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] p, input logic [31:0] i, input exp_t e);
    pc_present = p;
    inst = i;
    q.push_back(e);
  endtask
  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: got empty scoreboard expected an entry", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, ".valid"}, {31'b0, id_valid}, {31'b0, e.v});
    chk({tag, ".pc"}, id_pc, e.pc);
    chk({tag, ".inst"}, id_inst, e.ins);
    chk({tag, ".imm"}, imm, e.imm);
    chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, e.ill});
  endtask
  initial begin
    q.push_back('{v: 1'b0, pc: 32'h0, ins: 32'h13, imm: 32'h0, ill: 1'b0});
    tick;
    pop_check("reset");
    chk("reset.rs1_data", rs1_data, 32'h0);
    chk("reset.rs2_data", rs2_data, 32'h0);
    reset = 1'b0;
    drive(32'h20, 32'h0050_0093, '{1'b1, 32'h20, 32'h0050_0093, 32'h5, 1'b0});
    tick;
    pop_check("addi");
    chk("addi.rd", {27'b0, rd}, 32'd1);
    chk("addi.opcode", {25'b0, opcode}, 32'h13);
    drive(32'h24, 32'hFE20_8CE3, '{1'b1, 32'h24, 32'hFE20_8CE3, 32'hFFFF_FFF8, 1'b0});
    tick;
    pop_check("beq");
    chk("beq.rs1", {27'b0, rs1}, 32'd1);
    chk("beq.rs2", {27'b0, rs2}, 32'd2);
    chk("beq.funct3", {29'b0, funct3}, 32'd0);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF; stall = 1'b1;
    #1;
    chk("bypass.rs1_data", rs1_data, 32'hDEAD_BEEF);
    chk("bypass.rs2_data", rs2_data, 32'h0);
    drive(32'h99, 32'h0000_0033, '{1'b1, 32'h24, 32'hFE20_8CE3, 32'hFFFF_FFF8, 1'b0});
    tick;
    pop_check("stall_wb");
    wb_en = 1'b0;
    #1;
    chk("written.rs1_data", rs1_data, 32'hDEAD_BEEF);
    stall = 1'b0; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h5;
    drive(32'h28, 32'h0050_0093, '{1'b1, 32'h28, 32'h0050_0093, 32'h5, 1'b0});
    tick;
    pop_check("x0_load");
    chk("x0.bypass_rs1", rs1_data, 32'h0);
    wb_en = 1'b0;
    #1;
    chk("x0.after_write", rs1_data, 32'h0);
    stall = 1'b1;
    drive(32'h100, 32'h1234_5678, '{1'b1, 32'h28, 32'h0050_0093, 32'h5, 1'b0});
    tick;
    pop_check("stall1");
    drive(32'h104, 32'h8765_4321, '{1'b1, 32'h28, 32'h0050_0093, 32'h5, 1'b0});
    tick;
    pop_check("stall2");
    flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
    drive(32'h108, 32'h0020_A423, '{1'b0, 32'h28, 32'h13, 32'h0, 1'b0});
    tick;
    pop_check("stall_flush");
    flush = 1'b0; stall = 1'b0; wb_en = 1'b0;
    drive(32'h2C, 32'h0020_81B3, '{1'b1, 32'h2C, 32'h0020_81B3, 32'h0, 1'b0});
    tick;
    pop_check("add");
    chk("add.rs1_data", rs1_data, 32'hDEAD_BEEF);
    chk("add.rs2_data", rs2_data, 32'h55);
    chk("add.funct7", {25'b0, funct7}, 32'h0);
    drive(32'h30, 32'h0020_A423, '{1'b1, 32'h30, 32'h0020_A423, 32'h8, 1'b0});
    tick;
    pop_check("sw");
    drive(32'h34, 32'h1234_52B7, '{1'b1, 32'h34, 32'h1234_52B7, 32'h1234_5000, 1'b0});
    tick;
    pop_check("lui");
    drive(32'h38, 32'hFFDF_F0EF, '{1'b1, 32'h38, 32'hFFDF_F0EF, 32'hFFFF_FFFC, 1'b0});
    tick;
    pop_check("jal");
    drive(32'h40, 32'h0000_007F, '{1'b1, 32'h40, 32'h0000_007F, 32'h0, 1'b1});
    tick;
    pop_check("illegal");
    flush = 1'b1;
    drive(32'h44, 32'h0000_007F, '{1'b0, 32'h40, 32'h13, 32'h0, 1'b0});
    tick;
    pop_check("illegal_flush");
    flush = 1'b0;
    chk("scoreboard.drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
